// File: rtl/ste_microwire_lmc_pkg.sv
// rtl/ste_microwire_lmc_pkg.sv - shared constants and types for the STE Microwire / LMC1992 block
package ste_microwire_lmc_pkg;

  localparam logic [4:0] ADDR_DATA = 5'h11;
  localparam logic [4:0] ADDR_MASK = 5'h12;

  typedef enum logic [2:0] {
    CMD_MIX    = 3'd0,
    CMD_BASS   = 3'd1,
    CMD_TREBLE = 3'd2,
    CMD_MASTER = 3'd3,
    CMD_RIGHT  = 3'd4,
    CMD_LEFT   = 3'd5
  } lmc_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } mw_state_e;

  localparam logic [1:0] MIX_YM_12DB = 2'b00;
  localparam logic [1:0] MIX_YM      = 2'b01;

  localparam logic [5:0] MASTER_MAX = 6'd40;
  localparam logic [4:0] SIDE_MAX   = 5'd20;

  localparam logic [5:0] MASTER_RST = MASTER_MAX;
  localparam logic [4:0] SIDE_RST   = SIDE_MAX;
  localparam logic [1:0] MIX_RST    = MIX_YM;
  localparam logic [3:0] TONE_RST   = 4'd6;

  // Q1.15 gains for 0, -2 and -4 dB; coarse steps are 6 dB shifts
  localparam logic signed [17:0] COEF_FINE0 = 18'sd32768;
  localparam logic signed [17:0] COEF_FINE1 = 18'sd26029;
  localparam logic signed [17:0] COEF_FINE2 = 18'sd20675;

  function automatic logic signed [17:0] fine_coef(input logic [1:0] fine);
    case (fine)
      2'd0:    return COEF_FINE0;
      2'd1:    return COEF_FINE1;
      default: return COEF_FINE2;
    endcase
  endfunction

endpackage

// File: rtl/ste_microwire_lmc_attenuator.sv
// rtl/ste_microwire_lmc_attenuator.sv - per-channel YM/STE mix and 2-stage attenuation pipeline
module lmc_attenuator
  import ste_microwire_lmc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  ym,
  input  logic [7:0]  ste,
  input  logic [1:0]  mix,
  input  logic [5:0]  master,
  input  logic [4:0]  side,
  output logic [14:0] audio
);

  logic signed [14:0] y_ext, s_ext, mix_sum, mix_q, out_next, out_q;
  logic [6:0]         atten_idx, coarse;
  logic [1:0]         fine;
  logic signed [32:0] prod, scaled;
  logic               unused_scaled_hi;

  // Replicating the top bits fills the 15-bit range symmetrically
  assign y_ext = {ym[9], ym, ym[9:6]};
  assign s_ext = {ste[7], ste, ste[7:2]};

  always_comb begin
    mix_sum = s_ext;
    case (mix)
      MIX_YM:      mix_sum = y_ext + s_ext;
      MIX_YM_12DB: mix_sum = (y_ext >>> 2) + s_ext;
      default:     mix_sum = s_ext;
    endcase
  end

  assign atten_idx = 7'(MASTER_MAX - master) + 7'(SIDE_MAX - side);
  assign coarse    = atten_idx / 7'd3;
  assign fine      = 2'(atten_idx % 7'd3);
  assign prod      = 33'(mix_q) * 33'(fine_coef(fine));
  assign scaled    = (prod >>> 15) >>> coarse;
  assign out_next  = (coarse >= 7'd15) ? '0 : scaled[14:0];
  assign unused_scaled_hi = ^scaled[32:15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mix_q <= '0;
      out_q <= '0;
    end else begin
      mix_q <= mix_sum;
      out_q <= out_next;
    end
  end

  assign audio = out_q;

endmodule

// File: rtl/ste_microwire_lmc.sv
// rtl/ste_microwire_lmc.sv - STE Microwire master with LMC1992 command decode and volume/mix stage
module ste_microwire_lmc
  import ste_microwire_lmc_pkg::*;
#(
  parameter int         SHIFT_DIV = 2,
  parameter logic [1:0] CMD_ADDR  = 2'b10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_2_en,
  input  logic [15:0] din,
  input  logic [4:0]  addr,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  input  logic        sel,
  output logic [15:0] dout,
  input  logic [9:0]  ym_l,
  input  logic [9:0]  ym_r,
  input  logic [7:0]  ste_l,
  input  logic [7:0]  ste_r,
  output logic        busy,
  output logic [14:0] audio_mix_l,
  output logic [14:0] audio_mix_r
);

  mw_state_e   state, state_next;
  logic [15:0] data, mask;
  logic [10:0] acc, acc_next;
  logic [4:0]  cnt, cnt_next;
  logic [3:0]  step_cnt;
  logic [7:0]  div_cnt;
  logic        wr_req, wr_req_q, wr_stb, data_wr, mask_wr;
  logic        step_en, last_step, cmd_go;
  logic [5:0]  cmd_val;
  logic [5:0]  master;
  logic [4:0]  left_vol, right_vol;
  logic [1:0]  mix;
  logic [3:0]  bass, treble;
  logic        unused_tone;

  // A CPU write is acted on once, on the rising edge of the access
  assign wr_req  = sel & ~rw & (uds | lds);
  assign wr_stb  = wr_req & ~wr_req_q;
  assign data_wr = wr_stb && (addr == ADDR_DATA) && (state == ST_IDLE);
  assign mask_wr = wr_stb && (addr == ADDR_MASK) && (state == ST_IDLE);

  assign step_en   = (state == ST_SHIFT) && clk_2_en && (div_cnt == 8'(SHIFT_DIV - 1));
  assign last_step = step_en && (step_cnt == 4'd15);
  assign acc_next  = mask[15] ? {acc[9:0], data[15]} : acc;
  assign cnt_next  = (mask[15] && cnt != 5'd16) ? cnt + 5'd1 : cnt;
  assign cmd_go    = last_step && (cnt_next >= 5'd11) && (acc_next[10:9] == CMD_ADDR);
  assign cmd_val   = acc_next[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (data_wr)   state_next = ST_SHIFT;
      ST_SHIFT: if (last_step) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_q <= 1'b0;
      data     <= '0;
      mask     <= '0;
      acc      <= '0;
      cnt      <= '0;
      step_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      wr_req_q <= wr_req;
      if (mask_wr) mask <= din;
      if (data_wr) begin
        data     <= din;
        acc      <= '0;
        cnt      <= '0;
        step_cnt <= '0;
        div_cnt  <= '0;
      end else if (state == ST_SHIFT && clk_2_en) begin
        div_cnt <= step_en ? '0 : div_cnt + 8'd1;
        if (step_en) begin
          // 16 rotations restore data and mask to their written values
          acc      <= acc_next;
          cnt      <= cnt_next;
          data     <= {data[14:0], data[15]};
          mask     <= {mask[14:0], mask[15]};
          step_cnt <= step_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      master    <= MASTER_RST;
      left_vol  <= SIDE_RST;
      right_vol <= SIDE_RST;
      mix       <= MIX_RST;
      bass      <= TONE_RST;
      treble    <= TONE_RST;
    end else if (cmd_go) begin
      case (lmc_cmd_e'(acc_next[8:6]))
        CMD_MIX:    mix       <= cmd_val[1:0];
        CMD_BASS:   bass      <= cmd_val[3:0];
        CMD_TREBLE: treble    <= cmd_val[3:0];
        CMD_MASTER: master    <= (cmd_val > MASTER_MAX) ? MASTER_MAX : cmd_val;
        CMD_RIGHT:  right_vol <= (cmd_val > 6'(SIDE_MAX)) ? SIDE_MAX : cmd_val[4:0];
        CMD_LEFT:   left_vol  <= (cmd_val > 6'(SIDE_MAX)) ? SIDE_MAX : cmd_val[4:0];
        default: ;
      endcase
    end
  end

  // Tone settings are held for readback-free compatibility only
  assign unused_tone = ^{bass, treble};

  always_comb begin
    dout = 16'h0000;
    if (sel) begin
      if (addr == ADDR_DATA)      dout = data;
      else if (addr == ADDR_MASK) dout = mask;
    end
  end

  lmc_attenuator u_att_l (
    .clk     (clk),
    .reset_n (reset_n),
    .ym      (ym_l),
    .ste     (ste_l),
    .mix     (mix),
    .master  (master),
    .side    (left_vol),
    .audio   (audio_mix_l)
  );

  lmc_attenuator u_att_r (
    .clk     (clk),
    .reset_n (reset_n),
    .ym      (ym_r),
    .ste     (ste_r),
    .mix     (mix),
    .master  (master),
    .side    (right_vol),
    .audio   (audio_mix_r)
  );

endmodule
